// File: rtl/prio_mixer_ctrl_pkg.sv
// prio_mixer_ctrl_pkg: layer-select codes, PROM address bit positions, loader states, PROM geometry
package prio_mixer_ctrl_pkg;
  localparam int PROM_DEPTH = 256;
  localparam int PROM_W = 4;
  localparam int PROM_AW = 8;
  localparam logic [1:0] SEL_FIX = 2'd0;
  localparam logic [1:0] SEL_OBJ = 2'd1;
  localparam logic [1:0] SEL_VA = 2'd2;
  localparam logic [1:0] SEL_VB = 2'd3;
  localparam int A_OBP0 = 6;
  localparam int A_OBP1 = 5;
  localparam int A_OBP2 = 4;
  localparam int A_NFIX = 3;
  localparam int A_NOBJ = 2;
  localparam int A_NVB = 1;
  localparam int A_NVA = 0;
  typedef enum logic [1:0] {EMPTY, LOAD, READY} ld_state_t;
  function automatic logic [PROM_AW-1:0] prom_addr(input logic [2:0] obp, input logic nfix, input logic nobj, input logic nvb, input logic nva);
    logic [PROM_AW-1:0] a;
    a = '0;
    a[A_OBP0] = obp[2];
    a[A_OBP1] = obp[1];
    a[A_OBP2] = obp[0];
    a[A_NFIX] = nfix;
    a[A_NOBJ] = nobj;
    a[A_NVB] = nvb;
    a[A_NVA] = nva;
    return a;
  endfunction
endpackage

// File: rtl/prio_mixer_ctrl_if.sv
// prio_mixer_ctrl_if: pixel inputs/outputs and PROM download port; master drives pixels and downloads, slave is the mixer
interface prio_mixer_ctrl_if #(parameter int COLW = 11);
  logic pxl_ce;
  logic blankn;
  logic [2:0] obp;
  logic nfix, nobj, nvb, nva;
  logic [COLW-1:0] fix_col, obj_col, va_col, vb_col;
  logic [COLW-1:0] pxl_col;
  logic pxl_shadow;
  logic pxl_vld;
  logic dl_en;
  logic dl_wr;
  logic [7:0] dl_addr;
  logic [3:0] dl_data;
  logic prom_ok;
  logic dl_busy;
  modport master(
    output pxl_ce, blankn, obp, nfix, nobj, nvb, nva, fix_col, obj_col, va_col, vb_col, dl_en, dl_wr, dl_addr, dl_data,
    input pxl_col, pxl_shadow, pxl_vld, prom_ok, dl_busy
  );
  modport slave(
    input pxl_ce, blankn, obp, nfix, nobj, nvb, nva, fix_col, obj_col, va_col, vb_col, dl_en, dl_wr, dl_addr, dl_data,
    output pxl_col, pxl_shadow, pxl_vld, prom_ok, dl_busy
  );
endinterface

// File: rtl/prio_mixer_ctrl_prom_ram.sv
// prio_prom_ram: 256x4 priority PROM copy; one write port (we/wa/wd), one registered read port (re/ra -> q), read-before-write
module prio_prom_ram
  import prio_mixer_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PROM_AW-1:0] wa,
  input  logic [PROM_W-1:0]  wd,
  input  logic               re,
  input  logic [PROM_AW-1:0] ra,
  output logic [PROM_W-1:0]  q
);
  logic [PROM_W-1:0] mem [PROM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/prio_mixer_ctrl.sv
// prio_mixer_ctrl: per-pixel priority mixer; clk, resetn (async low), bus.slave carries pixel inputs/outputs and PROM download port
module prio_mixer_ctrl
  import prio_mixer_ctrl_pkg::*;
#(
  parameter int              COLW = 11,
  parameter logic [COLW-1:0] BACKDROP = '0
) (
  input logic              clk,
  input logic              resetn,
  prio_mixer_ctrl_if.slave bus
);
  ld_state_t st;
  logic [8:0] cnt;
  logic ok, busy, full, we, b1, p1, vld, sh, drop;
  logic [3:0][COLW-1:0] c1;
  logic [COLW-1:0] col;
  logic [PROM_W-1:0] q;
  assign full = cnt == 9'(PROM_DEPTH);
  assign we = st == LOAD && bus.dl_en && bus.dl_wr;
  assign drop = !b1 || !ok || q[3];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= EMPTY;
      cnt <= '0;
      ok <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (st)
        EMPTY, READY: if (bus.dl_en) begin
          st <= LOAD;
          cnt <= '0;
          ok <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: if (!bus.dl_en) begin
          st <= full ? READY : EMPTY;
          ok <= full;
          busy <= 1'b0;
        end else if (bus.dl_wr && !full) cnt <= cnt + 9'd1;
        default: st <= EMPTY;
      endcase
    end
  prio_prom_ram u_ram (
    .clk(clk),
    .we (we),
    .wa (bus.dl_addr),
    .wd (bus.dl_data),
    .re (bus.pxl_ce),
    .ra (prom_addr(bus.obp, bus.nfix, bus.nobj, bus.nvb, bus.nva)),
    .q  (q)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      c1 <= '0;
      b1 <= 1'b0;
      p1 <= 1'b0;
      vld <= 1'b0;
      col <= BACKDROP;
      sh <= 1'b0;
    end else if (bus.pxl_ce) begin
      c1[SEL_FIX] <= bus.fix_col;
      c1[SEL_OBJ] <= bus.obj_col;
      c1[SEL_VA] <= bus.va_col;
      c1[SEL_VB] <= bus.vb_col;
      b1 <= bus.blankn;
      p1 <= 1'b1;
      vld <= p1;
      col <= drop ? BACKDROP : c1[q[1:0]];
      sh <= !drop && q[2];
    end else vld <= 1'b0;
  assign bus.pxl_col = col;
  assign bus.pxl_shadow = sh;
  assign bus.pxl_vld = vld;
  assign bus.prom_ok = ok;
  assign bus.dl_busy = busy;
endmodule

// File: tb/tb_prio_mixer_ctrl.sv
// tb_prio_mixer_ctrl: directed stimulus with a cycle-level behavioural model and literal spot checks
module tb_prio_mixer_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int fails = 0;
  logic [3:0] tbl [256];
  prio_mixer_ctrl_if #(.COLW(11)) bus ();
  prio_mixer_ctrl #(.COLW(11), .BACKDROP(11'h000)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // behavioural model: table contents, download bookkeeping, and one pixel in flight
  logic [3:0] mram [256];
  int nwr = 0;
  bit loading = 0, ok_m = 0, have = 0, drop;
  logic [7:0] pa;
  logic pb;
  logic [10:0] pc [4];
  logic [3:0] pq;
  logic [10:0] e_col = 11'h000;
  logic e_sh = 1'b0, e_vld = 1'b0;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      loading = 0; ok_m = 0; have = 0; nwr = 0;
      e_col = 11'h000; e_sh = 0; e_vld = 0;
    end else begin
      if (bus.pxl_ce) begin
        if (have) begin
          drop = !pb || !ok_m || pq[3];
          e_col = drop ? 11'h000 : pc[pq[1:0]];
          e_sh = !drop && pq[2];
          e_vld = 1;
        end else begin
          e_col = 11'h000; e_sh = 0; e_vld = 0;
        end
        pa = {1'b0, bus.obp, bus.nfix, bus.nobj, bus.nvb, bus.nva};
        pb = bus.blankn;
        pc = '{bus.fix_col, bus.obj_col, bus.va_col, bus.vb_col};
        pq = mram[pa];
        have = 1;
      end else e_vld = 0;
      if (loading) begin
        if (!bus.dl_en) begin
          ok_m = nwr >= 256;
          loading = 0;
        end else if (bus.dl_wr) begin
          mram[bus.dl_addr] = bus.dl_data;
          nwr++;
        end
      end else if (bus.dl_en) begin
        loading = 1; nwr = 0; ok_m = 0;
      end
      #1;
      if (resetn) begin
        chk("m_col", 32'(bus.pxl_col), 32'(e_col));
        chk("m_shadow", 32'(bus.pxl_shadow), 32'(e_sh));
        chk("m_vld", 32'(bus.pxl_vld), 32'(e_vld));
        chk("m_prom_ok", 32'(bus.prom_ok), 32'(ok_m));
        chk("m_busy", 32'(bus.dl_busy), 32'(loading));
      end
    end
  end

  task automatic pix(input logic [7:0] a);
    bus.obp = a[6:4];
    bus.nfix = a[3];
    bus.nobj = a[2];
    bus.nvb = a[1];
    bus.nva = a[0];
  endtask

  task automatic wait2;
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input int n);
    bus.dl_en = 1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.dl_wr = 1;
      bus.dl_addr = i[7:0];
      bus.dl_data = tbl[i];
      @(negedge clk);
    end
    bus.dl_wr = 0;
    bus.dl_en = 0;
    repeat (2) @(negedge clk);
  endtask

  int nv;

  initial begin
    bus.pxl_ce = 0; bus.blankn = 1; pix(8'h00);
    bus.fix_col = 11'h123; bus.obj_col = 11'h2AA; bus.va_col = 11'h3C5; bus.vb_col = 11'h456;
    bus.dl_en = 0; bus.dl_wr = 0; bus.dl_addr = 0; bus.dl_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(bus.pxl_col), 32'h0);
    chk("rst_ok", 32'(bus.prom_ok), 32'h0);
    resetn = 1;
    bus.pxl_ce = 1;
    wait2;
    chk("noload_col", 32'(bus.pxl_col), 32'h0);
    chk("noload_ok", 32'(bus.prom_ok), 32'h0);
    for (int i = 0; i < 256; i++) tbl[i] = 4'(i & 3);
    load(256);
    chk("full_ok", 32'(bus.prom_ok), 32'h1);
    pix(8'h05);
    wait2;
    chk("a05_obj", 32'(bus.pxl_col), 32'h2AA);
    pix(8'h0E);
    wait2;
    chk("a0e_va", 32'(bus.pxl_col), 32'h3C5);
    pix(8'h05);
    load(255);
    chk("part_ok", 32'(bus.prom_ok), 32'h0);
    wait2;
    chk("part_col", 32'(bus.pxl_col), 32'h0);
    load(256);
    chk("reload_ok", 32'(bus.prom_ok), 32'h1);
    wait2;
    chk("reload_col", 32'(bus.pxl_col), 32'h2AA);
    tbl[0] = 4'h8;
    load(256);
    pix(8'h00);
    wait2;
    chk("q3_col", 32'(bus.pxl_col), 32'h0);
    tbl[0] = 4'h6;
    load(256);
    wait2;
    chk("e6_col", 32'(bus.pxl_col), 32'h3C5);
    chk("e6_shadow", 32'(bus.pxl_shadow), 32'h1);
    bus.blankn = 0;
    wait2;
    chk("blank_col", 32'(bus.pxl_col), 32'h0);
    chk("blank_shadow", 32'(bus.pxl_shadow), 32'h0);
    bus.blankn = 1;
    nv = 0;
    for (int k = 0; k < 32; k++) begin
      bus.pxl_ce = (k % 4 == 0);
      if (k % 4 == 0) pix(((k / 4) % 2 == 0) ? 8'h05 : 8'h0E);
      @(negedge clk);
      if (bus.pxl_vld) nv++;
      if (k == 4) chk("ce_lat_p0", 32'(bus.pxl_col), 32'h2AA);
      if (k == 8) chk("ce_lat_p1", 32'(bus.pxl_col), 32'h3C5);
    end
    chk("ce_vld_pulses", 32'(nv), 32'd8);
    chk("ce_hold_col", 32'(bus.pxl_col), 32'h2AA);
    bus.pxl_ce = 1;
    pix(8'h05);
    bus.dl_en = 1;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      bus.dl_wr = 1;
      bus.dl_addr = i[7:0];
      bus.dl_data = tbl[i];
      @(negedge clk);
    end
    chk("mid_busy", 32'(bus.dl_busy), 32'h1);
    resetn = 0;
    #1;
    chk("arst_ok", 32'(bus.prom_ok), 32'h0);
    chk("arst_busy", 32'(bus.dl_busy), 32'h0);
    chk("arst_col", 32'(bus.pxl_col), 32'h0);
    chk("arst_vld", 32'(bus.pxl_vld), 32'h0);
    bus.dl_wr = 0;
    bus.dl_en = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    wait2;
    chk("post_rst_ok", 32'(bus.prom_ok), 32'h0);
    chk("post_rst_col", 32'(bus.pxl_col), 32'h0);
    load(256);
    chk("redl_ok", 32'(bus.prom_ok), 32'h1);
    wait2;
    chk("redl_col", 32'(bus.pxl_col), 32'h2AA);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/prio_mixer_ctrl.md
Name: prio_mixer_ctrl

Overview:
Per-pixel priority sequencer for the tile/sprite mixer. Each pixel it forms the 8-bit priority-PROM address from the sprite priority bits and the four layer-transparency flags. It looks the address up in an internal 256x4 copy of the priority PROM and muxes the selected layer colour to the palette address bus. It also owns the PROM contents through a download port, and tracks whether a complete table is resident before honouring it.

Parameters:
COLW, 11, width of every layer colour code and of PXL_COL
BACKDROP, 0, colour code output when blanked, PROM not loaded, or Q3 set

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
PXL_CE  in  1  pixel clock enable; pipeline advances only when high
BLANKn  in  1  active display; low forces BACKDROP (stands in for PROM EN1n/EN2n)
OBP  in  3  sprite priority bits {OBP0,OBP1,OBP2}
NFIX, NOBJ, NVB, NVA  in  1 each  layer transparent flag (1 = transparent)
FIX_COL, OBJ_COL, VA_COL, VB_COL  in  COLW each  layer colour codes
PXL_COL  out  COLW  selected colour code
PXL_SHADOW  out  1  PROM Q2 of the displayed pixel
PXL_VLD  out  1  high for one CLK per advanced pixel
DL_EN  in  1  download window
DL_WR  in  1  write strobe, one entry per CLK
DL_ADDR  in  8  PROM entry address
DL_DATA  in  4  PROM entry {Q3,Q2,Q1,Q0}
PROM_OK  out  1  full table resident
DL_BUSY  out  1  loader in LOAD state

Behaviour:
- Reset: PXL_COL=BACKDROP, PXL_SHADOW=0, PXL_VLD=0, PROM_OK=0, DL_BUSY=0, write counter=0, FSM=EMPTY. PROM RAM contents are not reset.
- Address: A[7]=0, A[6]=OBP0, A[5]=OBP1, A[4]=OBP2, A[3]=NFIX, A[2]=NOBJ, A[1]=NVB, A[0]=NVA.
- Loader FSM states:
  - EMPTY -> LOAD on DL_EN=1.
  - LOAD: each DL_WR writes RAM[DL_ADDR]=DL_DATA and increments a 9-bit counter, saturating at 256. Writes outside DL_EN are ignored.
  - LOAD -> READY on DL_EN fall with counter=256. LOAD -> EMPTY on DL_EN fall with counter<256.
  - READY -> LOAD on DL_EN=1, which clears PROM_OK and the counter.
  - PROM_OK=1 only in READY. DL_BUSY=1 only in LOAD.
- Pipeline, advancing on PXL_CE=1 only:
  - S0 registers the address, the four colours and BLANKn.
  - S1 performs the synchronous RAM read and carries the colours.
  - S2 registers the output.
  - PXL_COL, PXL_SHADOW and PXL_VLD are registered; latency is 2 PXL_CE ticks from input sample to PXL_COL change.
- S2 selection:
  - If S1 blank, or PROM_OK=0, or Q3=1: PXL_COL=BACKDROP, PXL_SHADOW=0.
  - Otherwise Q[1:0] selects the colour: 0 FIX, 1 OBJ, 2 VA, 3 VB. PXL_SHADOW=Q2.
- PXL_VLD is PXL_CE delayed 2 ticks of PXL_CE activity. It is 0 on any CLK where PXL_CE=0.
- Simultaneous RAM write and read, same address, same CLK: the read returns old data. The output is still BACKDROP because PROM_OK=0 during LOAD.
- PROM_OK is sampled at S2. A pixel in flight when LOAD starts outputs BACKDROP.
- Reset mid-LOAD: back to EMPTY, table must be re-downloaded in full.
- PXL_CE held low: all pipeline registers hold their values.

Decomposition:
- Shared package holds:
  - the layer-select encoding constants (FIX=0, OBJ=1, VA=2, VB=3),
  - the PROM address bit positions,
  - the loader state enum (EMPTY, LOAD, READY),
  - PROM depth 256 / width 4.
- One sub-module, prio_prom_ram: 256x4 single-write / single-read synchronous RAM, read-enable = PXL_CE.

Test Plan:
- Reset, no download, opaque inputs, BLANKn=1, FIX_COL=0x123 -> PXL_COL=0x000 (BACKDROP), PROM_OK=0 throughout.
- Download all 256 entries with data = A[1:0], DL_EN falls -> PROM_OK=1. Address 0x05 (NOBJ=1, NVA=1) yields 0x05&3=1 -> PXL_COL=OBJ_COL=0x2AA two PXL_CE ticks after input.
- Download only 255 entries -> PROM_OK stays 0, output stays BACKDROP. Re-download all 256 -> PROM_OK=1.
- Entry 0x00=0x8 (Q3=1) -> BACKDROP. Entry 0x00=0x6 -> PXL_COL=VA_COL, PXL_SHADOW=1. BLANKn=0 on the same pixel -> BACKDROP, PXL_SHADOW=0.
- PXL_CE pulsed 1 in 4 CLK -> PXL_VLD single-CLK pulses. PXL_COL changes only on CE edges, with latency exactly 2 CE ticks.
- RESETn asserted mid-download (128 writes) -> PROM_OK=0, DL_BUSY=0 immediately (async). Outputs at reset values; full re-download required.
